// File: rtl/door_lock_controller.sv
// -----------------------------------------------------------------------------
// door_lock_controller
//
// Sits downstream of the colour-code detector. A press of the start button
// arms the controller, which then waits a bounded window for the detector's
// unlock flag. On success the door drive is held high for a fixed time. On
// failure a consecutive-failure count is bumped. Reaching MAX_FAILS puts the
// lock into a timed lockout. Lockout raises Alarm and blocks the start pulse
// forwarded to the detector.
//
// Ports:
//   Clk     in   system clock, all state changes on the rising edge
//   Reset   in   synchronous active-high reset, overrides everything
//   S       in   raw start button level
//   U       in   unlock flag from the code detector
//   S_out   out  start forwarded to the detector (combinational, gated)
//   Door    out  door unlock drive (registered)
//   Alarm   out  lockout indicator (registered)
//   FailCnt out  consecutive failed attempts, saturating (registered)
// -----------------------------------------------------------------------------
module door_lock_controller #(
    parameter int UNLOCK_CYCLES  = 8,
    parameter int WINDOW         = 6,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       S,
    input  logic       U,
    output logic       S_out,
    output logic       Door,
    output logic       Alarm,
    output logic [3:0] FailCnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_OPEN    = 2'b10,
        ST_LOCKOUT = 2'b11
    } state_t;

    // Last timer value of each timed state; the transition happens on the
    // edge where the timer already holds this value.
    localparam logic [7:0] WIN_LAST  = 8'(WINDOW - 1);
    localparam logic [7:0] OPEN_LAST = 8'(UNLOCK_CYCLES - 1);
    localparam logic [7:0] LOCK_LAST = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0] MAX_CNT   = 4'(MAX_FAILS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_timer;
    logic [7:0] w_timer_nxt;
    logic [3:0] r_fail_cnt;
    logic [3:0] w_fail_cnt_nxt;
    logic [3:0] w_fail_inc;
    logic       r_door;
    logic       r_alarm;

    // Saturating increment: the count never passes MAX_FAILS.
    assign w_fail_inc = (r_fail_cnt < MAX_CNT) ? (r_fail_cnt + 4'd1) : r_fail_cnt;

    // -------------------------------------------------------------------------
    // Next-state logic. The single timer is shared by ARMED, OPEN and
    // LOCKOUT and is forced to zero whenever a state is (re)entered.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer + 8'd1;
        w_fail_cnt_nxt = r_fail_cnt;
        case (r_state)
            ST_IDLE: begin
                w_timer_nxt = 8'd0;
                if (S) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (U) begin
                    // U takes priority over a simultaneous restart.
                    w_state_nxt    = ST_OPEN;
                    w_timer_nxt    = 8'd0;
                    w_fail_cnt_nxt = 4'd0;
                end else if (S) begin
                    // A new start restarts the window, as the detector does.
                    w_timer_nxt = 8'd0;
                end else if (r_timer == WIN_LAST) begin
                    w_timer_nxt    = 8'd0;
                    w_fail_cnt_nxt = w_fail_inc;
                    if (w_fail_inc == MAX_CNT) begin
                        w_state_nxt = ST_LOCKOUT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_OPEN: begin
                if (r_timer == OPEN_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = 8'd0;
                end
            end
            ST_LOCKOUT: begin
                if (r_timer == LOCK_LAST) begin
                    w_state_nxt    = ST_IDLE;
                    w_timer_nxt    = 8'd0;
                    w_fail_cnt_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = 8'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers. Door/Alarm are decoded from the next state
    // so they line up with the state they describe and can never overlap.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_timer    <= 8'd0;
            r_fail_cnt <= 4'd0;
            r_door     <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_fail_cnt <= w_fail_cnt_nxt;
            r_door     <= (w_state_nxt == ST_OPEN);
            r_alarm    <= (w_state_nxt == ST_LOCKOUT);
        end
    end

    // Start pass-through with no added latency; blocked only during lockout.
    assign S_out   = S & (r_state != ST_LOCKOUT);
    assign Door    = r_door;
    assign Alarm   = r_alarm;
    assign FailCnt = r_fail_cnt;

endmodule
